// File: rtl/icetap_pkg.sv
// Shared FSM encoding for the icetap sample-capture stage.
package icetap_pkg;

  localparam int STATE_W = 3;

  typedef enum logic [STATE_W-1:0] {
    IDLE  = 3'd0,
    ARMED = 3'd1,
    POST  = 3'd2,
    DONE  = 3'd3
  } state_t;

endpackage

// File: rtl/icetap_sample_ram.sv
// Simple dual-port sample RAM: one write port, one registered read port, no array reset.
module icetap_sample_ram #(
  parameter int W         = 1,
  parameter int DEPTH     = 256,
  parameter int ADDR_BITS = 8
) (
  input  logic                 clk,
  input  logic                 we,
  input  logic [ADDR_BITS-1:0] waddr,
  input  logic [W-1:0]         wdata,
  input  logic [ADDR_BITS-1:0] raddr,
  output logic [W-1:0]         rdata
);

  logic [W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    rdata <= mem[raddr];
  end

endmodule

// File: rtl/icetap_capture.sv
// Circular capture of signals_in around a one-bit trigger, with pre/post depth,
// plus a logical read port that presents the oldest held sample at index 0.
module icetap_capture
  import icetap_pkg::*;
#(
  parameter int NR_SIGNALS = 1,
  parameter int DEPTH      = 256,
  parameter int ADDR_BITS  = 8
) (
  input  logic                  clk,
  input  logic                  reset_,
  input  logic [NR_SIGNALS-1:0] signals_in,
  input  logic                  arm,
  input  logic                  abort,
  input  logic                  trigger,
  input  logic                  store,
  input  logic [ADDR_BITS-1:0]  post_cnt,
  input  logic [ADDR_BITS-1:0]  rd_addr,
  output logic [NR_SIGNALS-1:0] rd_data,
  output logic [STATE_W-1:0]    state_o,
  output logic                  done,
  output logic [ADDR_BITS:0]    num_samples,
  output logic [ADDR_BITS-1:0]  trigger_pos
);

  localparam logic [ADDR_BITS:0] FULL = (ADDR_BITS+1)'(DEPTH);

  state_t               state_q, state_d;
  logic [ADDR_BITS-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_BITS:0]   num_q, num_d;
  logic [ADDR_BITS-1:0] post_left_q, post_left_d;
  logic [ADDR_BITS-1:0] trig_abs_q, trig_abs_d;
  logic                 we;
  logic                 rd_zero_q;
  logic [ADDR_BITS-1:0] start;
  logic [NR_SIGNALS-1:0] ram_q;

  always_ff @(posedge clk) begin
    if (!reset_) begin
      state_q     <= IDLE;
      wr_ptr_q    <= '0;
      num_q       <= '0;
      post_left_q <= '0;
      trig_abs_q  <= '0;
    end else begin
      state_q     <= state_d;
      wr_ptr_q    <= wr_ptr_d;
      num_q       <= num_d;
      post_left_q <= post_left_d;
      trig_abs_q  <= trig_abs_d;
    end
  end

  // The RAM output has no reset, so rd_data is forced to zero for the cycle after reset.
  always_ff @(posedge clk) rd_zero_q <= !reset_;

  always_comb begin
    state_d     = state_q;
    wr_ptr_d    = wr_ptr_q;
    num_d       = num_q;
    post_left_d = post_left_q;
    trig_abs_d  = trig_abs_q;
    we          = 1'b0;

    if (arm) begin
      state_d     = ARMED;
      wr_ptr_d    = '0;
      num_d       = '0;
      post_left_d = post_cnt;
    end else if (abort) begin
      state_d = IDLE;
    end else begin
      unique case (state_q)
        ARMED: begin
          if (trigger) begin
            we         = 1'b1;
            trig_abs_d = wr_ptr_q;
            state_d    = (post_left_q == '0) ? DONE : POST;
          end else if (store) begin
            we = 1'b1;
          end
        end
        POST: begin
          if (store) begin
            we          = 1'b1;
            post_left_d = post_left_q - ADDR_BITS'(1);
            if (post_left_q == ADDR_BITS'(1)) state_d = DONE;
          end
        end
        default: ;
      endcase
    end

    if (we) begin
      wr_ptr_d = wr_ptr_q + ADDR_BITS'(1);
      if (num_q != FULL) num_d = num_q + (ADDR_BITS+1)'(1);
    end
  end

  // Once the buffer has wrapped, the oldest sample sits at the write pointer.
  assign start       = (num_q == FULL) ? wr_ptr_q : '0;
  assign trigger_pos = trig_abs_q - start;

  icetap_sample_ram #(
    .W        (NR_SIGNALS),
    .DEPTH    (DEPTH),
    .ADDR_BITS(ADDR_BITS)
  ) u_ram (
    .clk  (clk),
    .we   (we),
    .waddr(wr_ptr_q),
    .wdata(signals_in),
    .raddr(start + rd_addr),
    .rdata(ram_q)
  );

  assign rd_data     = rd_zero_q ? '0 : ram_q;
  assign state_o     = state_q;
  assign done        = (state_q == DONE);
  assign num_samples = num_q;

endmodule

// File: tb/tb_icetap_capture.sv
// Directed bench for icetap_capture (DEPTH=16) with a read-data scoreboard.
module tb_icetap_capture;

  logic       clk = 1'b0;
  logic       reset_;
  logic [7:0] signals_in;
  logic       arm, abort, trigger, store;
  logic [3:0] post_cnt, rd_addr;
  logic [7:0] rd_data;
  logic [2:0] state_o;
  logic       done;
  logic [4:0] num_samples;
  logic [3:0] trigger_pos;

  int errors = 0;
  int checks = 0;

  logic [7:0] hist [$];
  logic [7:0] exp_q [$];

  icetap_capture #(.NR_SIGNALS(8), .DEPTH(16), .ADDR_BITS(4)) dut (
    .clk        (clk),
    .reset_     (reset_),
    .signals_in (signals_in),
    .arm        (arm),
    .abort      (abort),
    .trigger    (trigger),
    .store      (store),
    .post_cnt   (post_cnt),
    .rd_addr    (rd_addr),
    .rd_data    (rd_data),
    .state_o    (state_o),
    .done       (done),
    .num_samples(num_samples),
    .trigger_pos(trigger_pos)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Arm cycle drives store/trigger high to show they are ignored there.
  task automatic do_arm(input int post);
    arm = 1'b1; post_cnt = 4'(post); store = 1'b1; trigger = 1'b1; signals_in = 8'hEE;
    step();
    arm = 1'b0; store = 1'b0; trigger = 1'b0;
    hist.delete();
    chk("arm_num", num_samples, 0);
    chk("arm_state", state_o, 1);
  endtask

  // Drives values 0,1,2,... one per cycle and records what the block should store.
  task automatic run_capture(input int post, input int trig_val, input bit even_only);
    int  left;
    bit  in_post, fin, st, tg;
    left = post; in_post = 0; fin = 0;
    do_arm(post);
    for (int v = 0; v < 200 && !fin; v++) begin
      st = even_only ? (v % 2 == 0) : 1'b1;
      tg = (v == trig_val);
      signals_in = 8'(v); store = st; trigger = tg;
      if (!in_post) begin
        if (tg) begin
          hist.push_back(8'(v));
          if (left == 0) fin = 1; else in_post = 1;
        end else if (st) hist.push_back(8'(v));
      end else if (st) begin
        hist.push_back(8'(v));
        left--;
        if (left == 0) fin = 1;
      end
      step();
    end
    store = 1'b0; trigger = 1'b0;
    chk("cap_done", done, 1);
    chk("cap_state", state_o, 3);
  endtask

  task automatic read_back(input string tag, input int n);
    int base;
    base = hist.size() - n;
    for (int i = 0; i < n; i++) begin
      rd_addr = 4'(i);
      exp_q.push_back(hist[base + i]);
      step();
      chk(tag, rd_data, exp_q.pop_front());
    end
  endtask

  task automatic check_capture(input string tag, input int exp_n, input int exp_pos);
    chk({tag, "_num"}, num_samples, exp_n);
    chk({tag, "_tpos"}, trigger_pos, exp_pos);
    read_back({tag, "_rd"}, exp_n);
  endtask

  initial begin
    reset_ = 1'b0; signals_in = '0; arm = 0; abort = 0; trigger = 0; store = 0;
    post_cnt = '0; rd_addr = '0;
    step(); step();
    chk("rst_state", state_o, 0);
    chk("rst_done", done, 0);
    chk("rst_num", num_samples, 0);
    chk("rst_tpos", trigger_pos, 0);
    chk("rst_rd", rd_data, 0);
    reset_ = 1'b1;
    step();

    // 1: wrapped buffer, trigger at 20 with 3 post samples
    run_capture(3, 20, 0);
    check_capture("s1", 16, 12);

    // 2: short capture, no wrap
    run_capture(3, 2, 0);
    check_capture("s2", 6, 2);
    chk("s2_done", done, 1);

    // 3: qualified store, trigger forces a write with store=0
    run_capture(2, 7, 1);
    check_capture("s3", 7, 4);

    // 4: post_cnt=DEPTH-1 puts the trigger at logical index 0
    run_capture(15, 30, 0);
    check_capture("s4", 16, 0);

    // 5: arm during POST, abort in ARMED, arm+abort together
    do_arm(10);
    for (int v = 0; v < 6; v++) begin
      signals_in = 8'(v); store = 1'b1; trigger = (v == 3);
      step();
    end
    store = 0; trigger = 0;
    chk("s5_post", state_o, 2);
    do_arm(0);
    for (int v = 100; v < 104; v++) begin
      signals_in = 8'(v); store = 1'b1;
      step();
    end
    store = 0;
    chk("s5_num4", num_samples, 4);
    abort = 1'b1; step(); abort = 1'b0;
    chk("s5_abort_state", state_o, 0);
    chk("s5_abort_num", num_samples, 4);
    chk("s5_abort_tpos", trigger_pos, 3);
    for (int v = 0; v < 3; v++) begin
      signals_in = 8'(v); store = 1'b1; trigger = 1'b1;
      step();
    end
    store = 0; trigger = 0;
    chk("s5_idle_num", num_samples, 4);
    chk("s5_idle_state", state_o, 0);
    arm = 1'b1; abort = 1'b1; post_cnt = 4'd0; step(); arm = 1'b0; abort = 1'b0;
    chk("s5_both_state", state_o, 1);
    chk("s5_both_num", num_samples, 0);
    hist.delete();
    for (int v = 200; v < 203; v++) begin
      signals_in = 8'(v); store = 1'b1; trigger = (v == 202);
      hist.push_back(8'(v));
      step();
    end
    store = 0; trigger = 0;
    chk("s5_done", done, 1);
    check_capture("s5", 3, 2);

    // 6: reset mid-POST, then a clean capture
    do_arm(3);
    for (int v = 0; v < 7; v++) begin
      signals_in = 8'(v); store = 1'b1; trigger = (v == 5);
      step();
    end
    store = 0; trigger = 0;
    chk("s6_post", state_o, 2);
    reset_ = 1'b0; step(); reset_ = 1'b1;
    chk("s6_rst_state", state_o, 0);
    chk("s6_rst_done", done, 0);
    chk("s6_rst_num", num_samples, 0);
    chk("s6_rst_rd", rd_data, 0);
    chk("s6_rst_tpos", trigger_pos, 0);
    run_capture(3, 20, 0);
    check_capture("s6", 16, 12);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
